// File: rtl/acc_buf_pkg.sv
// Shared constants, width helpers and entry layout for the accumulator-side
// elastic buffer.
package acc_buf_pkg;

  localparam int ACC_SIZE  = 8;
  localparam int ACC_LANES = 2;
  localparam int ACC_DEPTH = 4;

  // Occupancy counter must be able to hold the value Depth itself.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic [ACC_LANES*ACC_SIZE-1:0] data;
    logic                          done;
  } acc_entry_t;

endpackage

// File: rtl/acc_buf_ptr.sv
// Modulo-Depth pointer for the buffer; Depth need not be a power of two.
module acc_buf_ptr
  import acc_buf_pkg::*;
#(
  parameter int Depth = ACC_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          inc,
  output logic [ptr_width(Depth)-1:0]   ptr
);

  localparam int PW = ptr_width(Depth);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_nxt_s;

  // next pointer value with explicit wrap at the last index
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (inc) begin
      if (ptr_r == PW'(Depth - 1)) begin
        ptr_nxt_s = '0;
      end else begin
        ptr_nxt_s = ptr_r + PW'(1);
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // pointer register, clear has priority over advance
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (clr) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/acc_fifo_buffer.sv
// First-word-fall-through elastic buffer between multiplier array and
// accumulator, with done-tag tracking, flush and occupancy reporting.
module acc_fifo_buffer
  import acc_buf_pkg::*;
#(
  parameter int Size  = ACC_SIZE,
  parameter int Lanes = ACC_LANES,
  parameter int Depth = ACC_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [Lanes*Size-1:0]         in_data,
  input  logic                          in_done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [Lanes*Size-1:0]         out_data,
  output logic                          out_done,
  output logic [occ_width(Depth)-1:0]   level,
  output logic                          done_pending
);

  localparam int W  = Lanes * Size;
  localparam int LW = occ_width(Depth);
  localparam int PW = ptr_width(Depth);

  typedef struct packed {
    logic [W-1:0] data;
    logic         done;
  } entry_t;

  entry_t        mem_r [Depth];
  logic [PW-1:0] wr_ptr_s;
  logic [PW-1:0] rd_ptr_s;
  logic [LW-1:0] level_r;
  logic [LW-1:0] done_cnt_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          done_pending_r;

  logic          push_s;
  logic          pop_s;
  logic          head_done_s;
  logic [LW-1:0] level_nxt_s;
  logic [LW-1:0] done_cnt_nxt_s;

  assign push_s = in_valid & in_ready_r;
  assign pop_s  = out_valid_r & out_ready;

  acc_buf_ptr #(.Depth(Depth)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push_s),
    .ptr (wr_ptr_s)
  );

  acc_buf_ptr #(.Depth(Depth)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop_s),
    .ptr (rd_ptr_s)
  );

  // storage write; contents are never cleared, emptiness is handled by masking
  always_ff @(posedge clk) begin
    if (push_s && !rst && !flush) begin
      mem_r[wr_ptr_s] <= '{data: in_data, done: in_done};
    end
  end

  assign head_done_s = mem_r[rd_ptr_s].done;

  // next occupancy and done-tag count from this cycle's push/pop
  always_comb begin
    level_nxt_s    = level_r;
    done_cnt_nxt_s = done_cnt_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
    case ({push_s & in_done, pop_s & head_done_s})
      2'b10:   done_cnt_nxt_s = done_cnt_r + LW'(1);
      2'b01:   done_cnt_nxt_s = done_cnt_r - LW'(1);
      default: done_cnt_nxt_s = done_cnt_r;
    endcase
  end

  // status registers; flags are precomputed so no port sees a comb path
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      level_r        <= '0;
      done_cnt_r     <= '0;
      in_ready_r     <= 1'b1;
      out_valid_r    <= 1'b0;
      done_pending_r <= 1'b0;
    end else begin
      level_r        <= level_nxt_s;
      done_cnt_r     <= done_cnt_nxt_s;
      in_ready_r     <= (level_nxt_s != LW'(Depth));
      out_valid_r    <= (level_nxt_s != LW'(0));
      done_pending_r <= (done_cnt_nxt_s != LW'(0));
    end
  end

  // head presentation, forced to zero while empty
  always_comb begin
    out_data = '0;
    out_done = 1'b0;
    if (out_valid_r) begin
      out_data = mem_r[rd_ptr_s].data;
      out_done = mem_r[rd_ptr_s].done;
    end else begin
      out_data = '0;
      out_done = 1'b0;
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign level        = level_r;
  assign done_pending = done_pending_r;

endmodule

// File: tb/tb_acc_fifo_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model, on a Depth=4 and a Depth=3 instance.
module tb_acc_fifo_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fl4, iv4, idn4, or4, ir4, ov4, odn4, dp4;
  logic [15:0] id4, od4;
  logic [2:0]  lv4;
  logic        fl3, iv3, idn3, or3, ir3, ov3, odn3, dp3;
  logic [15:0] id3, od3;
  logic [1:0]  lv3;

  int checks = 0;
  int errors = 0;

  logic [16:0] q4[$];
  logic [16:0] q3[$];

  acc_fifo_buffer #(.Size(8), .Lanes(2), .Depth(4)) dut4 (
    .clk(clk), .rst(rst), .flush(fl4), .in_valid(iv4), .in_ready(ir4),
    .in_data(id4), .in_done(idn4), .out_valid(ov4), .out_ready(or4),
    .out_data(od4), .out_done(odn4), .level(lv4), .done_pending(dp4)
  );

  acc_fifo_buffer #(.Size(8), .Lanes(2), .Depth(3)) dut3 (
    .clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_ready(ir3),
    .in_data(id3), .in_done(idn3), .out_valid(ov3), .out_ready(or3),
    .out_data(od3), .out_done(odn3), .level(lv3), .done_pending(dp3)
  );

  function automatic logic [15:0] m_head(input logic [16:0] q[$]);
    logic [16:0] e;
    if (q.size() == 0) return 16'h0000;
    e = q[0];
    return e[16:1];
  endfunction

  function automatic logic m_head_done(input logic [16:0] q[$]);
    logic [16:0] e;
    if (q.size() == 0) return 1'b0;
    e = q[0];
    return e[0];
  endfunction

  function automatic logic m_any_done(input logic [16:0] q[$]);
    logic [16:0] e;
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      if (e[0]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic cyc4(input logic v, input logic [15:0] d, input logic dn,
                      input logic r, input logic f);
    bit p, po;
    iv4 = v; id4 = d; idn4 = dn; or4 = r; fl4 = f;
    @(posedge clk);
    if (rst || f) begin
      q4.delete();
    end else begin
      p  = v && (q4.size() < 4);
      po = r && (q4.size() != 0);
      if (po) void'(q4.pop_front());
      if (p) q4.push_back({d, dn});
    end
    #1;
  endtask

  task automatic cyc3(input logic v, input logic [15:0] d, input logic dn,
                      input logic r, input logic f);
    bit p, po;
    iv3 = v; id3 = d; idn3 = dn; or3 = r; fl3 = f;
    @(posedge clk);
    if (rst || f) begin
      q3.delete();
    end else begin
      p  = v && (q3.size() < 3);
      po = r && (q3.size() != 0);
      if (po) void'(q3.pop_front());
      if (p) q3.push_back({d, dn});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fork
      begin cyc4(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0); cyc4(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0); end
      begin cyc3(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0); cyc3(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0); end
    join
    rst = 1'b0;
    iv4 = 1'b0; iv3 = 1'b0;
    checks++; if (lv4 !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", lv4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov4); end
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", ir4); end
    checks++; if (od4 !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", od4); end
    checks++; if (dp4 !== 1'b0) begin errors++; $display("FAIL reset_done_pending got=%b exp=0", dp4); end
    checks++; if (lv3 !== 2'd0 || ov3 !== 1'b0 || ir3 !== 1'b1) begin
      errors++; $display("FAIL reset_d3 got lvl=%0d ov=%b ir=%b exp 0/0/1", lv3, ov3, ir3);
    end
    cyc4(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    checks++; if (lv4 !== 3'd0 || ov4 !== 1'b0) begin
      errors++; $display("FAIL reset_nothing_stored got lvl=%0d ov=%b exp 0/0", lv4, ov4);
    end
  endtask

  task automatic test_fill_drain();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h0102; exp_seq[1] = 16'h0304; exp_seq[2] = 16'h0506; exp_seq[3] = 16'h0708;
    for (int i = 0; i < 4; i++) cyc4(1'b1, exp_seq[i], 1'b0, 1'b0, 1'b0);
    checks++; if (lv4 !== 3'd4 || ir4 !== 1'b0) begin
      errors++; $display("FAIL fill_full got lvl=%0d ir=%b exp 4/0", lv4, ir4);
    end
    cyc4(1'b1, 16'h090A, 1'b0, 1'b0, 1'b0);
    checks++; if (lv4 !== 3'd4 || od4 !== 16'h0102) begin
      errors++; $display("FAIL fill_refused got lvl=%0d head=%h exp 4/0102", lv4, od4);
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (od4 !== exp_seq[i] || ov4 !== 1'b1) begin
        errors++; $display("FAIL drain_order[%0d] got=%h ov=%b exp=%h", i, od4, ov4, exp_seq[i]);
      end
      cyc4(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    end
    checks++; if (lv4 !== 3'd0 || ov4 !== 1'b0) begin
      errors++; $display("FAIL drain_empty got lvl=%0d ov=%b exp 0/0", lv4, ov4);
    end
    or4 = 1'b0;
  endtask

  task automatic test_wrap();
    int nxt;
    bit tog;
    logic [15:0] got[$];
    nxt = 0; tog = 1'b1;
    for (int c = 0; c < 100 && got.size() < 10; c++) begin
      logic v, acc;
      v   = (nxt < 10);
      acc = v && ir3;
      if (ov3 && tog) got.push_back(od3);
      cyc3(v, 16'(nxt), 1'b0, tog, 1'b0);
      if (acc) nxt++;
      tog = ~tog;
      checks++; if (lv3 !== 2'(q3.size()) || od3 !== m_head(q3)) begin
        errors++; $display("FAIL wrap_state got lvl=%0d head=%h exp %0d/%h", lv3, od3, q3.size(), m_head(q3));
      end
    end
    checks++; if (got.size() != 10) begin
      errors++; $display("FAIL wrap_count got=%0d exp=10", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 16'(i)) begin
        errors++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, got[i], 16'(i));
      end
    end
    iv3 = 1'b0; or3 = 1'b0;
  endtask

  task automatic test_simul();
    cyc4(1'b1, 16'hA0A0, 1'b0, 1'b0, 1'b0);
    cyc4(1'b1, 16'hB0B0, 1'b0, 1'b0, 1'b0);
    cyc4(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0);
    checks++; if (lv4 !== 3'd2 || od4 !== 16'hB0B0) begin
      errors++; $display("FAIL simul_mid got lvl=%0d head=%h exp 2/b0b0", lv4, od4);
    end
    cyc4(1'b1, 16'hC0C0, 1'b0, 1'b0, 1'b0);
    cyc4(1'b1, 16'hD0D0, 1'b0, 1'b0, 1'b0);
    cyc4(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0);
    checks++; if (lv4 !== 3'd3 || od4 !== 16'h1111) begin
      errors++; $display("FAIL simul_full got lvl=%0d head=%h exp 3/1111", lv4, od4);
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (od4 !== m_head(q4)) begin
        errors++; $display("FAIL simul_drain[%0d] got=%h exp=%h", i, od4, m_head(q4));
      end
      cyc4(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    end
    checks++; if (lv4 !== 3'd0) begin
      errors++; $display("FAIL simul_not_stored got lvl=%0d exp=0", lv4);
    end
    or4 = 1'b0;
  endtask

  task automatic test_done_tag();
    logic dn [3];
    dn[0] = 1'b0; dn[1] = 1'b0; dn[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc4(1'b1, 16'(i + 1), dn[i], 1'b0, 1'b0);
      checks++; if (dp4 !== (i == 2)) begin
        errors++; $display("FAIL done_push[%0d] got=%b exp=%b", i, dp4, (i == 2));
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (odn4 !== dn[i]) begin
        errors++; $display("FAIL done_out[%0d] got=%b exp=%b", i, odn4, dn[i]);
      end
      cyc4(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      checks++; if (dp4 !== (i < 2)) begin
        errors++; $display("FAIL done_pop[%0d] got=%b exp=%b", i, dp4, (i < 2));
      end
    end
    or4 = 1'b0;
  endtask

  task automatic test_flush();
    cyc4(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    cyc4(1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    cyc4(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    checks++; if (lv4 !== 3'd3 || dp4 !== 1'b1) begin
      errors++; $display("FAIL flush_pre got lvl=%0d dp=%b exp 3/1", lv4, dp4);
    end
    cyc4(1'b1, 16'h5555, 1'b1, 1'b1, 1'b1);
    checks++; if (lv4 !== 3'd0 || ov4 !== 1'b0 || dp4 !== 1'b0 || od4 !== 16'h0000) begin
      errors++; $display("FAIL flush_clear got lvl=%0d ov=%b dp=%b od=%h exp 0/0/0/0000", lv4, ov4, dp4, od4);
    end
    cyc4(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0);
    checks++; if (ov4 !== 1'b1 || od4 !== 16'hABCD || lv4 !== 3'd1) begin
      errors++; $display("FAIL flush_after got ov=%b od=%h lvl=%0d exp 1/abcd/1", ov4, od4, lv4);
    end
    cyc4(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    or4 = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cyc4(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
      checks++;
      if (lv4 !== 3'(q4.size()) || ir4 !== (q4.size() < 4) || ov4 !== (q4.size() != 0) ||
          od4 !== m_head(q4) || odn4 !== m_head_done(q4) || dp4 !== m_any_done(q4)) begin
        errors++;
        $display("FAIL random[%0d] got lvl=%0d ir=%b ov=%b od=%h odn=%b dp=%b exp lvl=%0d od=%h odn=%b dp=%b",
                 c, lv4, ir4, ov4, od4, odn4, dp4, q4.size(), m_head(q4), m_head_done(q4), m_any_done(q4));
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    fl4 = 1'b0; iv4 = 1'b0; idn4 = 1'b0; or4 = 1'b0; id4 = 16'h0000;
    fl3 = 1'b0; iv3 = 1'b0; idn3 = 1'b0; or3 = 1'b0; id3 = 16'h0000;
    #2;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simul();
    test_done_tag();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
